// File: rtl/network_div_pkg.sv
// Shared widths, FSM state type and saturation limits for the network divider.
package network_div_pkg;

  localparam int DIVIDEND_W = 30;
  localparam int DIVISOR_W  = 14;
  localparam int QUOT_W     = 16;
  localparam int CNT_W      = $clog2(DIVIDEND_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [QUOT_W-1:0] QUOT_MAX = 16'h7fff;
  localparam logic [QUOT_W-1:0] QUOT_MIN = 16'h8000;

  // Largest quotient magnitudes that fit without clamping, per sign.
  localparam logic [DIVIDEND_W-1:0] QMAG_POS_LIM = DIVIDEND_W'(32767);
  localparam logic [DIVIDEND_W-1:0] QMAG_NEG_LIM = DIVIDEND_W'(32768);

endpackage

// File: rtl/network_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract.
module network_div_step
  import network_div_pkg::*;
(
  input  logic [DIVISOR_W:0]   pr_in,
  input  logic                 bit_in,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W:0]   pr_out,
  output logic                 q_bit
);

  logic [DIVISOR_W:0] shifted;

  // pr_in is always below the divisor, so its top bit is zero and nothing is lost.
  always_comb begin
    shifted = {pr_in[DIVISOR_W-1:0], bit_in};
    q_bit   = (shifted >= {1'b0, divisor});
    pr_out  = q_bit ? (shifted - {1'b0, divisor}) : shifted;
  end

endmodule

// File: rtl/network_div_30s_14ns_16_seq.sv
// Sequential 30s/14u restoring divider with saturated 16-bit signed quotient.
// Optional remainder output enabled by defining NETWORK_DIV_REM_EN.
module network_div_30s_14ns_16_seq
  import network_div_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] din0,
  input  logic [DIVISOR_W-1:0]  din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [QUOT_W-1:0]     dout,
  output logic [DIVISOR_W:0]    rem,
  output logic                  ovf,
  output logic                  dz,
  output state_t                dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both
  // high; in_ready is high only in IDLE, out_valid only in DONE and it holds
  // the result stable until out_ready is seen.

  state_t                state, state_nxt;
  logic                  neg, dz_pend;
  logic [DIVIDEND_W-1:0] shreg;
  logic [DIVISOR_W-1:0]  divisor;
  logic [DIVISOR_W:0]    pr, pr_nxt;
  logic [CNT_W-1:0]      count;
  logic                  q_bit;
  logic [QUOT_W-1:0]     q_fix;
  logic                  ovf_fix;

  network_div_step u_step (
    .pr_in   (pr),
    .bit_in  (shreg[DIVIDEND_W-1]),
    .divisor (divisor),
    .pr_out  (pr_nxt),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = (din1 != '0) ? CALC : FIX;
      CALC: if (count == '0) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign dbg_state = state;

  // shreg holds the dividend magnitude; quotient bits enter at the LSB as dividend
  // bits leave the MSB, so after DIVIDEND_W steps it holds the quotient magnitude.
  always_comb begin
    q_fix   = shreg[QUOT_W-1:0];
    ovf_fix = 1'b0;
    if (dz_pend) begin
      q_fix = neg ? QUOT_MIN : QUOT_MAX;
    end else if (neg) begin
      if (shreg > QMAG_NEG_LIM) begin
        q_fix   = QUOT_MIN;
        ovf_fix = 1'b1;
      end else begin
        q_fix = -shreg[QUOT_W-1:0];
      end
    end else if (shreg > QMAG_POS_LIM) begin
      q_fix   = QUOT_MAX;
      ovf_fix = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      neg     <= 1'b0;
      dz_pend <= 1'b0;
      shreg   <= '0;
      divisor <= '0;
      pr      <= '0;
      count   <= '0;
      dout    <= '0;
      ovf     <= 1'b0;
      dz      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          neg     <= din0[DIVIDEND_W-1];
          shreg   <= din0[DIVIDEND_W-1] ? -din0 : din0;
          divisor <= din1;
          pr      <= '0;
          count   <= CNT_W'(DIVIDEND_W - 1);
          dz_pend <= (din1 == '0);
        end
        CALC: begin
          pr    <= pr_nxt;
          shreg <= {shreg[DIVIDEND_W-2:0], q_bit};
          if (count != '0) count <= count - CNT_W'(1);
        end
        FIX: begin
          dout <= q_fix;
          ovf  <= ovf_fix;
          dz   <= dz_pend;
        end
        default: ;
      endcase
    end
  end

`ifdef NETWORK_DIV_REM_EN
  logic [DIVISOR_W:0] rem_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem_q <= '0;
    end else if (state == FIX) begin
      if (dz_pend) rem_q <= '0;
      else         rem_q <= neg ? -pr : pr;
    end
  end

  assign rem = rem_q;
`else
  assign rem = '0;
`endif

endmodule

// File: doc/network_div_30s_14ns_16_seq.md
# network_div_30s_14ns_16_seq

Sequential signed divider that reverses the scaling applied by the 16s×14ns product multipliers in the network datapath. It takes a 30-bit signed accumulator/product and a 14-bit unsigned scale factor, and returns a saturated 16-bit signed quotient. An optional remainder is also available. It sits after the accumulate stage, where activations are renormalised before the next layer, and uses a valid/ready handshake on both sides.

## Interface
- DIVIDEND_W, 30, dividend width, signed; sets the iteration count.
- DIVISOR_W, 14, divisor width, unsigned.
- QUOT_W, 16, quotient width, signed, saturated.
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset; 0 clears all state immediately.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept; high only in IDLE.
- din0  in  DIVIDEND_W  signed dividend.
- din1  in  DIVISOR_W  unsigned divisor.
- out_valid  out  1  result present; held until consumed.
- out_ready  in  1  consumer accepts the result.
- dout  out  QUOT_W  signed quotient, truncated toward zero, saturated.
- rem  out  DIVISOR_W+1  signed remainder; its sign follows the dividend.
- ovf  out  1  quotient was saturated.
- dz  out  1  divisor was zero.

## Operation
- States: IDLE, CALC, FIX, DONE.
- **IDLE:** in_ready=1.
  - When in_valid&in_ready, latch sign(din0), |din0| as a DIVIDEND_W-bit unsigned value (|−2^29| = 2^29 fits), din1 and count=DIVIDEND_W−1.
  - If din1≠0, go to CALC; otherwise go to FIX with dz pending.
- **CALC:** one restoring step per cycle, MSB first.
  - Shift the partial remainder (DIVISOR_W+1 bits) left by one and bring in the next dividend bit.
  - If the partial remainder ≥ divisor, subtract and set the quotient bit to 1.
  - When count reaches 0, go to FIX; otherwise decrement count.
- **FIX:** restore signs, saturate, and register outputs.
  - Quotient magnitude is DIVIDEND_W bits. If negative, negate it.
  - Clamp to [−32768, +32767]. ovf=1 if clamped.
  - rem = ±remainder magnitude, using the dividend's sign.
  - If dz: dout=+32767 when din0≥0 and −32768 when din0<0, rem=0, ovf=0, dz=1.
  - Then go to DONE.
- **DONE:** out_valid=1. dout/rem/ovf/dz stay stable while out_valid=1 and out_ready=0. When out_ready=1, go to IDLE.
- A dividend of 0 with a nonzero divisor gives dout=0, rem=0 and no flags.
- in_valid in a non-IDLE state is ignored; no input is dropped because in_ready=0.

## Timing
- Reset values: state=IDLE; in_ready=1; out_valid=0; dout=0, rem=0, ovf=0, dz=0; count=0.
- Latency is measured from the accept edge to the edge that raises out_valid:
  - DIVIDEND_W+1 = 31 cycles for a nonzero divisor.
  - 1 cycle for a zero divisor.
- Throughput: the next accept occurs no earlier than the cycle after the output handshake. Minimum period is 33 cycles.
- out_valid deasserts on the edge that completes the output handshake. in_ready rises on the same edge.
- Reset asserted in any state aborts the operation and forces the reset values asynchronously. The first accept is possible on the first edge after release.

## Configuration
- NETWORK_DIV_REM_EN defined: remainder register and sign-fixup logic are present, and rem is driven as specified.
- Not defined: rem is tied to 0 and its register is removed. Quotient, flags and timing are unchanged.

## Structure
- Package network_div_pkg holds:
  - width constants (30/14/16);
  - the state enum (IDLE, CALC, FIX, DONE);
  - QUOT_MAX (+32767) and QUOT_MIN (−32768) saturation constants.
- Sub-module network_div_step is one combinational restoring step:
  - inputs: partial remainder, next dividend bit, divisor;
  - outputs: new partial remainder and quotient bit.
- The FSM, counter and FIX logic stay in the top module.

## Test plan
- din0=1000, din1=7 → dout=142, rem=6, ovf=0, dz=0; out_valid 31 cycles after accept.
- din0=−1000, din1=7 → dout=−142, rem=−6.
- din0=536870911, din1=1 → dout=32767, ovf=1.
- din0=−536870912, din1=1 → dout=−32768, ovf=1.
- din0=−5, din1=0 → dout=−32768, dz=1, rem=0; out_valid 1 cycle after accept.
- Hold out_ready=0 for 5 cycles after out_valid:
  - outputs stay stable and in_ready=0;
  - in_valid pulses are ignored;
  - after out_ready=1, the next accept completes 1 cycle later.
- Assert reset mid-CALC (count=12):
  - outputs go to reset values immediately;
  - after release, 1000/7 completes correctly with no residue from the aborted operation.
